// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared encodings for the memory access unit
// Holds the mem_size codes, fault codes, FSM states, the latched op fields
// and the alignment legality check used by the top level.
package mem_access_unit_pkg;
  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam logic [1:0] MEM_RSV = 2'b11;
  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_ALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
  typedef struct packed {
    logic branch;
    logic zero;
    logic rd;
    logic wr;
    logic [1:0] size;
    logic uns;
    logic dest;
  } op_t;
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
    return size == MEM_RSV || (size == MEM_H && off[0]) || (size == MEM_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational store lane replication / byte enables and load extract / extend
// Ports: size, off (address[1:0]), uns (zero-extend), wdata (store data),
//        rdata (bus read data) -> st_data (replicated store data),
//        be (byte enables), ld_data (extended load data).
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] ld_data
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = 8'(rdata >> {off, 3'b000});
    h = off[1] ? rdata[31:16] : rdata[15:0];
    st_data = size == MEM_B ? {4{wdata[7:0]}} : size == MEM_H ? {2{wdata[15:0]}} : wdata;
    be = size == MEM_B ? 4'b0001 << off : size == MEM_H ? 4'b0011 << off : 4'b1111;
    ld_data = size == MEM_B ? {{24{b[7] & ~uns}}, b} : size == MEM_H ? {{16{h[15] & ~uns}}, h} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle memory stage between execute and write-back
// Ports: clk, rst (sync, active-low); in_valid/in_ready handshake from execute;
//        ex_result, ex_zero, is_branch_op, mem_read, mem_write, mem_size,
//        mem_unsigned, write_data, dest_reg_prog_in op fields;
//        out_valid, is_valid_branch, dest_reg_prog_out, memory_res,
//        original_value, fault results; bus_req/we/addr/wdata/be, bus_ack,
//        bus_rdata data bus.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              ex_zero,
  input  logic              is_branch_op,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [XLEN-1:0]   write_data,
  input  logic              dest_reg_prog_in,
  output logic              out_valid,
  output logic              is_valid_branch,
  output logic              dest_reg_prog_out,
  output logic [XLEN-1:0]   memory_res,
  output logic [XLEN-1:0]   original_value,
  output logic [1:0]        fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_be,
  input  logic              bus_ack,
  input  logic [XLEN-1:0]   bus_rdata
);
  localparam int CW = $clog2(TIMEOUT + 2);
  state_t state, next;
  op_t in_op, op_q, cur;
  logic [XLEN-1:0] addr_q, wd_q, cur_addr, cur_wd, st_data, ld_data;
  logic [XLEN/8-1:0] be;
  logic [CW-1:0] cnt;
  logic accept, mem_op, bad, cnt_hit;
  logic [1:0] fault_n;
  // In IDLE the op under decision is the one on the inputs; afterwards it is the latched copy.
  assign in_op = '{is_branch_op, ex_zero, mem_read, mem_write, mem_size, mem_unsigned, dest_reg_prog_in};
  assign in_ready = state == S_IDLE;
  assign accept = in_valid & in_ready;
  assign cur = in_ready ? in_op : op_q;
  assign cur_addr = in_ready ? ex_result : addr_q;
  assign cur_wd = in_ready ? write_data : wd_q;
  assign mem_op = cur.rd | cur.wr;
  assign bad = mem_op & bad_access(cur.size, cur_addr[1:0]);
  assign cnt_hit = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  mem_lane_align u_lane (
    .size    (cur.size),
    .off     (cur_addr[1:0]),
    .uns     (cur.uns),
    .wdata   (cur_wd),
    .rdata   (bus_rdata),
    .st_data (st_data),
    .be      (be),
    .ld_data (ld_data)
  );
  // An ack on the cycle the count expires still wins over the timeout.
  always_comb begin
    next = state == S_IDLE ? (accept ? (mem_op && !bad ? S_BUS : S_RESP) : S_IDLE)
         : state == S_BUS ? (bus_ack || cnt_hit ? S_RESP : S_BUS)
         : S_IDLE;
    fault_n = state == S_BUS ? (bus_ack ? FLT_NONE : FLT_TIMEOUT) : (bad ? FLT_ALIGN : FLT_NONE);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      op_q <= '0;
      addr_q <= '0;
      wd_q <= '0;
      cnt <= '0;
      fault <= FLT_NONE;
      memory_res <= '0;
      original_value <= '0;
      is_valid_branch <= 1'b0;
      dest_reg_prog_out <= 1'b0;
    end else begin
      state <= next;
      cnt <= state == S_BUS && next == S_BUS ? cnt + 1'b1 : '0;
      if (accept) begin
        op_q <= in_op;
        addr_q <= ex_result;
        wd_q <= write_data;
      end
      if (next == S_RESP) begin
        fault <= fault_n;
        memory_res <= state == S_BUS && bus_ack && cur.rd && !cur.wr ? ld_data : '0;
        original_value <= cur_addr;
        is_valid_branch <= cur.branch & cur.zero;
        dest_reg_prog_out <= cur.dest & (fault_n == FLT_NONE);
      end
    end
  end
  assign out_valid = state == S_RESP;
  assign bus_req = state == S_BUS;
  assign bus_we = bus_req & op_q.wr;
  assign bus_addr = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_wdata = bus_req ? st_data : '0;
  assign bus_be = bus_req ? be : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a behavioural model
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  logic clk = 0, rst = 0, in_valid = 0, ex_zero = 0, is_branch_op = 0, mem_read = 0, mem_write = 0;
  logic mem_unsigned = 0, dest_reg_prog_in = 0, bus_ack = 0;
  logic [1:0] mem_size = 0;
  logic [31:0] ex_result = 0, write_data = 0, bus_rdata = 0;
  logic in_ready, out_valid, is_valid_branch, dest_reg_prog_out, bus_req, bus_we;
  logic [31:0] memory_res, original_value, bus_addr, bus_wdata;
  logic [1:0] fault;
  logic [3:0] bus_be;
  int total = 0, bad = 0;
  int ob_lat, ob_req;
  logic ob_stable, ob_we, ob_dest, ob_br, ob_ov_next, ob_rdy_next, ob_ready_pre;
  logic [31:0] ob_addr, ob_wdata, ob_mres, ob_orig;
  logic [3:0] ob_be;
  logic [1:0] ob_fault;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ex_result(ex_result),
    .ex_zero(ex_zero), .is_branch_op(is_branch_op), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .write_data(write_data),
    .dest_reg_prog_in(dest_reg_prog_in), .out_valid(out_valid), .is_valid_branch(is_valid_branch),
    .dest_reg_prog_out(dest_reg_prog_out), .memory_res(memory_res), .original_value(original_value),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic legal(input logic [1:0] sz, input logic [31:0] a);
    return sz != 2'd3 && (a % nbytes(sz)) == 0;
  endfunction
  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] r;
    int off = int'(a % 4);
    for (int i = 0; i < 4; i++) r[i] = i >= off && i < off + nbytes(sz);
    return r;
  endfunction
  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(sz);
    logic [31:0] v;
    if (n == 4) return rd;
    v = (rd >> (8 * (a % 4))) & ((32'd1 << (8 * n)) - 1);
    if (!uns && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // Presents one op, plays the bus slave (ack after ack_after BUS cycles, 0 = never) and records what it saw.
  task automatic run_op(input logic br, z, rd, wr, input logic [1:0] sz, input logic uns, dst,
                        input logic [31:0] a, wd, rdata, input int ack_after);
    logic done;
    done = 0;
    @(negedge clk);
    ob_ready_pre = in_ready;
    is_branch_op = br; ex_zero = z; mem_read = rd; mem_write = wr; mem_size = sz;
    mem_unsigned = uns; dest_reg_prog_in = dst; ex_result = a; write_data = wd; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    ex_result = $urandom; write_data = $urandom; mem_size = 2'($urandom); mem_unsigned = 1'($urandom);
    mem_read = 1'($urandom); mem_write = 1'($urandom); dest_reg_prog_in = 1'($urandom);
    ob_lat = 0; ob_req = 0; ob_stable = 1;
    while (!done && ob_lat < 100) begin
      @(negedge clk);
      ob_lat++;
      if (out_valid) begin
        done = 1;
        ob_mres = memory_res; ob_fault = fault; ob_dest = dest_reg_prog_out;
        ob_br = is_valid_branch; ob_orig = original_value;
      end else if (bus_req) begin
        ob_req++;
        if (ob_req == 1) begin
          ob_addr = bus_addr; ob_we = bus_we; ob_wdata = bus_wdata; ob_be = bus_be;
        end else if (bus_addr !== ob_addr || bus_we !== ob_we || bus_wdata !== ob_wdata || bus_be !== ob_be) ob_stable = 0;
        bus_rdata = $urandom;
        if (ack_after != 0 && ob_req == ack_after) begin
          bus_ack = 1;
          bus_rdata = rdata;
        end
      end
      @(posedge clk);
      #1 bus_ack = 0;
    end
    @(negedge clk);
    ob_ov_next = out_valid;
    ob_rdy_next = in_ready;
  endtask

  task automatic test_reset;
    rst = 0; in_valid = 1; mem_read = 1; mem_size = MEM_W; ex_result = 32'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus_req !== 0) begin bad++; $display("FAIL rst_bus_req got=%h exp=0", bus_req); end
    total++; if (out_valid !== 0) begin bad++; $display("FAIL rst_out_valid got=%h exp=0", out_valid); end
    total++; if (fault !== 0) begin bad++; $display("FAIL rst_fault got=%h exp=0", fault); end
    total++; if ({memory_res, original_value, is_valid_branch, dest_reg_prog_out} !== '0) begin
      bad++; $display("FAIL rst_outputs got=%h/%h/%h/%h exp=0", memory_res, original_value, is_valid_branch, dest_reg_prog_out);
    end
    in_valid = 0; mem_read = 0; rst = 1;
    @(negedge clk);
    total++; if (in_ready !== 1 || out_valid !== 0) begin bad++; $display("FAIL rst_release got=%h/%h exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_word_store;
    run_op(0, 0, 0, 1, MEM_W, 0, 1, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    total++; if (ob_ready_pre !== 1) begin bad++; $display("FAIL ws_ready got=%h exp=1", ob_ready_pre); end
    total++; if (ob_addr !== 32'h100) begin bad++; $display("FAIL ws_addr got=%h exp=100", ob_addr); end
    total++; if (ob_be !== 4'b1111 || ob_we !== 1) begin bad++; $display("FAIL ws_be_we got=%b/%b exp=1111/1", ob_be, ob_we); end
    total++; if (ob_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ws_wdata got=%h exp=deadbeef", ob_wdata); end
    total++; if (ob_req !== 2 || ob_stable !== 1) begin bad++; $display("FAIL ws_req got=%0d/%b exp=2/1", ob_req, ob_stable); end
    total++; if (ob_lat !== 3) begin bad++; $display("FAIL ws_latency got=%0d exp=3", ob_lat); end
    total++; if (ob_fault !== FLT_NONE || ob_dest !== 1) begin bad++; $display("FAIL ws_fault got=%h/%b exp=0/1", ob_fault, ob_dest); end
    total++; if (ob_ov_next !== 0 || ob_rdy_next !== 1) begin bad++; $display("FAIL ws_one_cycle got=%b/%b exp=0/1", ob_ov_next, ob_rdy_next); end
  endtask

  task automatic test_byte_load;
    run_op(0, 0, 1, 0, MEM_B, 0, 1, 32'h103, 32'h0, 32'h80FF1234, 1);
    total++; if (ob_mres !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_signed got=%h exp=ffffff80", ob_mres); end
    total++; if (ob_addr !== 32'h100 || ob_we !== 0) begin bad++; $display("FAIL lb_addr got=%h/%b exp=100/0", ob_addr, ob_we); end
    total++; if (ob_lat !== 2) begin bad++; $display("FAIL lb_latency got=%0d exp=2", ob_lat); end
    run_op(0, 0, 1, 0, MEM_B, 1, 1, 32'h103, 32'h0, 32'h80FF1234, 1);
    total++; if (ob_mres !== 32'h00000080) begin bad++; $display("FAIL lbu_unsigned got=%h exp=00000080", ob_mres); end
  endtask

  task automatic test_half;
    run_op(0, 0, 0, 1, MEM_H, 0, 0, 32'h202, 32'h0000ABCD, 32'h0, 1);
    total++; if (ob_wdata !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata got=%h exp=abcdabcd", ob_wdata); end
    total++; if (ob_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b exp=1100", ob_be); end
    run_op(0, 0, 1, 0, MEM_H, 0, 1, 32'h201, 32'h0, 32'h12345678, 1);
    total++; if (ob_req !== 0) begin bad++; $display("FAIL lh_mis_bus got=%0d exp=0", ob_req); end
    total++; if (ob_fault !== FLT_ALIGN || ob_dest !== 0) begin bad++; $display("FAIL lh_mis_fault got=%h/%b exp=1/0", ob_fault, ob_dest); end
    total++; if (ob_lat !== 1 || ob_mres !== 0) begin bad++; $display("FAIL lh_mis_lat got=%0d/%h exp=1/0", ob_lat, ob_mres); end
  endtask

  task automatic test_timeout;
    run_op(0, 0, 1, 0, MEM_W, 0, 1, 32'h300, 32'h0, 32'h0, 0);
    total++; if (ob_req !== 16) begin bad++; $display("FAIL to_req_cycles got=%0d exp=16", ob_req); end
    total++; if (ob_fault !== FLT_TIMEOUT || ob_mres !== 0 || ob_dest !== 0) begin
      bad++; $display("FAIL to_result got=%h/%h/%b exp=2/0/0", ob_fault, ob_mres, ob_dest);
    end
    total++; if (ob_lat !== 17 || ob_rdy_next !== 1) begin bad++; $display("FAIL to_latency got=%0d/%b exp=17/1", ob_lat, ob_rdy_next); end
    run_op(0, 0, 1, 0, MEM_W, 0, 1, 32'h304, 32'h0, 32'h5A5A1234, 16);
    total++; if (ob_fault !== FLT_NONE || ob_mres !== 32'h5A5A1234 || ob_lat !== 17) begin
      bad++; $display("FAIL to_last_ack got=%h/%h/%0d exp=0/5a5a1234/17", ob_fault, ob_mres, ob_lat);
    end
  endtask

  task automatic test_branch;
    run_op(1, 1, 0, 0, MEM_W, 0, 0, 32'h40, 32'h0, 32'h0, 1);
    total++; if (ob_lat !== 1 || ob_req !== 0) begin bad++; $display("FAIL br_timing got=%0d/%0d exp=1/0", ob_lat, ob_req); end
    total++; if (ob_br !== 1 || ob_orig !== 32'h40 || ob_mres !== 0) begin
      bad++; $display("FAIL br_result got=%b/%h/%h exp=1/40/0", ob_br, ob_orig, ob_mres);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    is_branch_op = 0; mem_read = 1; mem_write = 0; mem_size = MEM_W; ex_result = 32'h400; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    total++; if (bus_req !== 1) begin bad++; $display("FAIL rm_req_up got=%b exp=1", bus_req); end
    rst = 0;
    @(posedge clk);
    #1 rst = 1; bus_ack = 1; bus_rdata = 32'h12345678;
    @(negedge clk);
    total++; if (bus_req !== 0 || out_valid !== 0) begin bad++; $display("FAIL rm_after_rst got=%b/%b exp=0/0", bus_req, out_valid); end
    @(posedge clk);
    #1 bus_ack = 0;
    @(negedge clk);
    total++; if (out_valid !== 0 || bus_req !== 0 || in_ready !== 1 || memory_res !== 0) begin
      bad++; $display("FAIL rm_late_ack got=%b/%b/%b/%h exp=0/0/1/0", out_valid, bus_req, in_ready, memory_res);
    end
    run_op(0, 0, 1, 0, MEM_W, 0, 1, 32'h500, 32'h0, 32'hCAFEF00D, 1);
    total++; if (ob_mres !== 32'hCAFEF00D || ob_lat !== 2 || ob_fault !== 0) begin
      bad++; $display("FAIL rm_next_op got=%h/%0d/%h exp=cafef00d/2/0", ob_mres, ob_lat, ob_fault);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      logic br, z, rd, wr, uns, dst, mem, ok;
      logic [1:0] sz;
      logic [31:0] a, wd, rdata;
      int ack;
      br = 1'($urandom); z = 1'($urandom); rd = 1'($urandom); wr = 1'($urandom);
      uns = 1'($urandom); dst = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = $urandom; if ($urandom_range(0, 1)) a = a & ~32'h3;
      wd = $urandom; rdata = $urandom; ack = $urandom_range(1, 4);
      mem = rd | wr;
      ok = !mem || legal(sz, a);
      run_op(br, z, rd, wr, sz, uns, dst, a, wd, rdata, ack);
      total++; if (ob_lat !== (mem && ok ? ack + 1 : 1) || ob_req !== (mem && ok ? ack : 0)) begin
        bad++; $display("FAIL rnd%0d_timing got=%0d/%0d exp=%0d/%0d", k, ob_lat, ob_req, mem && ok ? ack + 1 : 1, mem && ok ? ack : 0);
      end
      total++; if (ob_fault !== (ok ? FLT_NONE : FLT_ALIGN) || ob_dest !== (dst & ok)) begin
        bad++; $display("FAIL rnd%0d_fault got=%h/%b exp=%h/%b", k, ob_fault, ob_dest, ok ? FLT_NONE : FLT_ALIGN, dst & ok);
      end
      total++; if (ob_mres !== (rd && !wr && ok ? exp_load(sz, uns, a, rdata) : 32'h0)) begin
        bad++; $display("FAIL rnd%0d_mres got=%h exp=%h", k, ob_mres, rd && !wr && ok ? exp_load(sz, uns, a, rdata) : 32'h0);
      end
      total++; if (ob_br !== (br & z) || ob_orig !== a || ob_ov_next !== 0) begin
        bad++; $display("FAIL rnd%0d_pass got=%b/%h/%b exp=%b/%h/0", k, ob_br, ob_orig, ob_ov_next, br & z, a);
      end
      if (mem && ok) begin
        total++; if (ob_addr !== (a & ~32'h3) || ob_we !== wr || ob_stable !== 1) begin
          bad++; $display("FAIL rnd%0d_bus got=%h/%b/%b exp=%h/%b/1", k, ob_addr, ob_we, ob_stable, a & ~32'h3, wr);
        end
        if (wr) begin
          total++; if (ob_wdata !== exp_wdata(sz, wd) || ob_be !== exp_be(sz, a)) begin
            bad++; $display("FAIL rnd%0d_store got=%h/%b exp=%h/%b", k, ob_wdata, ob_be, exp_wdata(sz, wd), exp_be(sz, a));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_word_store;
    test_byte_load;
    test_half;
    test_timeout;
    test_branch;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
